// File: rtl/receiver.sv
`default_nettype none
// ============================================================================
// Module   : receiver
// Brief    : Serial-to-parallel receive stage, MSB first, with valid/ack
//            handshake, truncated-frame and overrun reporting.
// Revision : 1.0 - initial release
// ============================================================================
module receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             wake,
    input  logic             ack,
    output logic [WIDTH-1:0] parout,
    output logic             data_valid,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_shift    = 2'd1;
    localparam logic [1:0] c_wait_low = 2'd2;

    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    logic [1:0]       r_state, w_state_nx;
    logic [WIDTH-1:0] r_shreg, w_shreg_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic [WIDTH-1:0] r_parout, w_parout_nx;
    logic             r_data_valid, w_data_valid_nx;
    logic             r_frame_err;
    logic             r_overrun, w_overrun_nx;
    logic             r_busy;
    logic             w_complete;
    logic             w_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_idle;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_parout     <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_shreg      <= w_shreg_nx;
            r_cnt        <= w_cnt_nx;
            r_parout     <= w_parout_nx;
            r_data_valid <= w_data_valid_nx;
            r_frame_err  <= w_abort;
            r_overrun    <= w_overrun_nx;
            r_busy       <= (w_state_nx != c_idle);
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_shreg_nx  = r_shreg;
        w_cnt_nx    = r_cnt;
        w_parout_nx = r_parout;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            c_idle: begin
                if (wake) begin
                    w_shreg_nx = {{(WIDTH-1){1'b0}}, serial_in};
                    w_cnt_nx   = c_one;
                    w_state_nx = c_shift;
                end
            end
            c_shift: begin
                if (wake) begin
                    if (r_cnt == c_last) begin
                        w_parout_nx = {r_shreg[WIDTH-2:0], serial_in};
                        w_complete  = 1'b1;
                        w_cnt_nx    = '0;
                        w_state_nx  = c_wait_low;
                    end else begin
                        w_shreg_nx = {r_shreg[WIDTH-2:0], serial_in};
                        w_cnt_nx   = r_cnt + c_one;
                    end
                end else begin
                    w_abort    = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = c_idle;
                end
            end
            c_wait_low: begin
                // Bits arriving while wake stays high past a full frame are dropped.
                if (!wake) begin
                    w_state_nx = c_idle;
                end
            end
            default: begin
                w_state_nx = c_idle;
            end
        endcase
    end

    always_comb begin
        w_data_valid_nx = r_data_valid;
        w_overrun_nx    = r_overrun;
        if (w_complete) begin
            // An ack on the completing edge consumes the old frame, so no overrun.
            w_data_valid_nx = 1'b1;
            w_overrun_nx    = ack ? 1'b0 : (r_overrun | r_data_valid);
        end else if (ack) begin
            w_data_valid_nx = 1'b0;
            w_overrun_nx    = 1'b0;
        end
    end

    assign parout     = r_parout;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule
`default_nettype wire
